// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multicycle HI/LO multiply/divide unit. A start request in IDLE latches the
//   operands and runs WIDTH shift-add (multiply) or restoring-division
//   iterations. A FIX cycle applies the sign correction and writes hi/lo, and
//   done then pulses for one cycle. mthi/mtlo writes load hi/lo from a_output
//   while the unit is idle.
//
//   Optional feature: define MULTDIV_UNSIGNED_EN so that op[1] = 1 selects the
//   unsigned operations (multu/divu). When it is undefined, op[1] is ignored
//   and every operation is signed.
//
// Ports
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   one-cycle request, sampled only in IDLE
//   op        in   [2]  00 mult, 01 div, 10 multu, 11 divu
//   a_output  in   [WIDTH] rs operand (multiplicand / dividend); mthi/mtlo data
//   b_output  in   [WIDTH] rt operand (multiplier / divisor)
//   hi_write  in   mthi strobe
//   lo_write  in   mtlo strobe
//   hi        out  [WIDTH] product upper half / remainder
//   lo        out  [WIDTH] product lower half / quotient
//   busy      out  high in CALC and FIX
//   done      out  one-cycle completion pulse
//   div_zero  out  set by a divide with b_output == 0, cleared by the next start
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_output,
  input  logic [WIDTH-1:0] b_output,
  input  logic             hi_write,
  input  logic             lo_write,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      iter_reg;
  // Multiply: {upper accumulator, multiplier shifting out}.
  // Divide:   {remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   opd_reg;      // multiplicand or divisor magnitude
  logic               is_div_reg;
  logic               neg_q_reg;    // operand signs differ
  logic               neg_r_reg;    // dividend was negative
  logic               div_zero_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;

  // Operand decode
  logic             op_signed;
`ifdef MULTDIV_UNSIGNED_EN
  assign op_signed = ~op[1];
`else
  logic unused_op;
  assign unused_op = op[1];
  assign op_signed = 1'b1;
`endif

  logic             a_neg, b_neg, start_div_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg          = op_signed & a_output[WIDTH-1];
  assign b_neg          = op_signed & b_output[WIDTH-1];
  assign a_mag          = a_neg ? -a_output : a_output;
  assign b_mag          = b_neg ? -b_output : b_output;
  assign start_div_zero = op[0] & (b_output == '0);

  // One shift-add multiply step; the extra sum bit is the carry that the
  // right shift moves into the top of the accumulator.
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign add_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? opd_reg : '0)};
  assign mul_next = {add_sum, acc_reg[WIDTH-1:1]};

  // One restoring-division step. The remainder is always below the divisor,
  // so the shifted value fits WIDTH+1 bits and diff[WIDTH] is the borrow.
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_keep;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opd_reg};
  assign div_keep  = ~div_diff[WIDTH];
  assign div_next  = {(div_keep ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc_reg[WIDTH-2:0], div_keep};

  // Sign correction applied in FIX
  logic [WIDTH-1:0] fix_hi, fix_lo;
  always_comb begin
    fix_hi = acc_reg[2*WIDTH-1:WIDTH];
    fix_lo = acc_reg[WIDTH-1:0];
    if (is_div_reg) begin
      if (neg_q_reg) fix_lo = -acc_reg[WIDTH-1:0];
      if (neg_r_reg) fix_hi = -acc_reg[2*WIDTH-1:WIDTH];
    end else if (neg_q_reg) begin
      {fix_hi, fix_lo} = -acc_reg;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // FSM next state and outputs
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = start_div_zero ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (iter_reg == LAST_ITER) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iter_reg     <= '0;
      acc_reg      <= '0;
      opd_reg      <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            iter_reg     <= '0;
            is_div_reg   <= op[0];
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            div_zero_reg <= start_div_zero;
            if (op[0]) begin
              acc_reg <= {{WIDTH{1'b0}}, a_mag};
              opd_reg <= b_mag;
            end else begin
              acc_reg <= {{WIDTH{1'b0}}, b_mag};
              opd_reg <= a_mag;
            end
          end else begin
            if (hi_write) hi_reg <= a_output;
            if (lo_write) lo_reg <= a_output;
          end
        end
        CALC: begin
          iter_reg <= iter_reg + CW'(1);
          acc_reg  <= is_div_reg ? div_next : mul_next;
        end
        FIX: begin
          hi_reg <= fix_hi;
          lo_reg <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign div_zero = div_zero_reg;

endmodule
